// File: rtl/text_vram_write_buffer_pkg.sv
// Shared defines for the text VRAM write buffer: default sizes, text memory map, entry and state types.
package text_vram_write_buffer_pkg;

  localparam int unsigned DEPTH_DEF  = 8;
  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 8;

  // Text memory window as seen by the memory adapter.
  localparam int unsigned TEXT_MEM_BASE = 32'h000B_8000;
  localparam int unsigned TEXT_MEM_SIZE = 32'h0000_1000;

  // One buffered character write: VRAM-relative byte address and the character byte.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } text_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_BLOCKED = 2'd2
  } wb_state_e;

endpackage

// File: rtl/text_vram_write_buffer_sync_fifo_ram.sv
// Circular entry store with wrapping pointers, registered level/full and in-place overwrite of the newest entry.
module sync_fifo_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 24,
  parameter int unsigned KEY_W = 16,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             ovr_i,
  input  logic [W-1:0]     wdata_i,
  output logic [W-1:0]     rdata_o,
  output logic [KEY_W-1:0] newest_key_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] last_ptr_c;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             full_q;

  // Newest entry sits one slot behind the write pointer; occupancy after this edge.
  always_comb begin
    last_ptr_c = wr_ptr_q - PTR_W'(1);
    level_d    = level_q + LVL_W'(push_i) - LVL_W'(pop_i);
  end

  // Storage: append on push, otherwise overwrite the newest entry when coalescing.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end else if (ovr_i) begin
      mem_q[last_ptr_c] <= wdata_i;
    end
  end

  // Pointers, level and full flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
      full_q  <= (level_d == LVL_W'(DEPTH));
    end
  end

  assign rdata_o      = mem_q[rd_ptr_q];
  assign newest_key_o = mem_q[last_ptr_c][W-1 -: KEY_W];
  assign level_o      = level_q;
  assign full_o       = full_q;

endmodule

// File: rtl/text_vram_write_buffer.sv
// Buffers text-port byte writes and drains them to VRAM whenever scanout leaves the port free.
module text_vram_write_buffer
  import text_vram_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     scan_busy,
  input  logic                     overflow_clr,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     vram_we,
  output logic [ADDR_W-1:0]        vram_addr,
  output logic [DATA_W-1:0]        vram_data,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  logic [ENT_W-1:0]  rdata_w;
  logic [ADDR_W-1:0] newest_addr_w;
  logic [LVL_W-1:0]  level_w;
  logic              full_w;

  logic              pop_c;
  logic              push_c;
  logic              coalesce_c;
  logic              drop_c;
  logic [LVL_W-1:0]  level_nxt_c;

  wb_state_e         state_q;
  logic              vram_we_q;
  logic [ADDR_W-1:0] vram_addr_q;
  logic [DATA_W-1:0] vram_data_q;
  logic              overflow_q;
  logic [7:0]        drop_count_q;

  sync_fifo_ram #(
    .DEPTH (DEPTH),
    .W     (ENT_W),
    .KEY_W (ADDR_W),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push_c),
    .pop_i        (pop_c),
    .ovr_i        (coalesce_c),
    .wdata_i      ({wr_addr, wr_data}),
    .rdata_o      (rdata_w),
    .newest_key_o (newest_addr_w),
    .level_o      (level_w),
    .full_o       (full_w)
  );

  // Pop/coalesce/push/drop decisions; the newest entry is only off-limits when it is also the one leaving.
  always_comb begin
    pop_c       = (state_q != ST_IDLE) && !scan_busy;
    coalesce_c  = wr_en && (level_w != '0) && (wr_addr == newest_addr_w)
                  && !(pop_c && (level_w == LVL_W'(1)));
    push_c      = wr_en && !coalesce_c && (!full_w || pop_c);
    drop_c      = wr_en && !coalesce_c && !push_c;
    level_nxt_c = level_w + LVL_W'(push_c) - LVL_W'(pop_c);
  end

  // Control state and registered VRAM write port; a push into an empty FIFO waits one cycle before popping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      vram_we_q   <= 1'b0;
      vram_addr_q <= '0;
      vram_data_q <= '0;
    end else begin
      if (level_nxt_c == '0) begin
        state_q <= ST_IDLE;
      end else if (scan_busy) begin
        state_q <= ST_BLOCKED;
      end else begin
        state_q <= ST_DRAIN;
      end
      vram_we_q <= pop_c;
      if (pop_c) begin
        vram_addr_q <= rdata_w[ENT_W-1 -: ADDR_W];
        vram_data_q <= rdata_w[DATA_W-1:0];
      end
    end
  end

  // Sticky overflow and saturating drop counter; a drop in the clear cycle restarts the count at one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else if (drop_c) begin
      overflow_q <= 1'b1;
      if (overflow_clr) begin
        drop_count_q <= 8'd1;
      end else if (drop_count_q != 8'hFF) begin
        drop_count_q <= drop_count_q + 8'd1;
      end
    end else if (overflow_clr) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end
  end

  assign full       = full_w;
  assign level      = level_w;
  assign vram_we    = vram_we_q;
  assign vram_addr  = vram_addr_q;
  assign vram_data  = vram_data_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_text_vram_write_buffer.sv
// Scoreboard bench for text_vram_write_buffer: directed writes, expected VRAM writes queued, monitor compares.
module tb_text_vram_write_buffer;
  import text_vram_write_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        scan_busy;
  logic        overflow_clr;
  logic        full;
  logic [3:0]  level;
  logic        vram_we;
  logic [15:0] vram_addr;
  logic [7:0]  vram_data;
  logic        overflow;
  logic [7:0]  drop_count;

  text_entry_t exp_q[$];
  text_entry_t mon_e;
  int checks = 0;
  int failures = 0;
  int vram_writes = 0;
  int w0;

  text_vram_write_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .scan_busy    (scan_busy),
    .overflow_clr (overflow_clr),
    .full         (full),
    .level        (level),
    .vram_we      (vram_we),
    .vram_addr    (vram_addr),
    .vram_data    (vram_data),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
    text_entry_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while ((level != 4'd0 || vram_we) && n < 40) begin
      tick();
      n++;
    end
    chk(name, 32'(n < 40), 32'd1);
  endtask

  // Monitor: every VRAM write must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && vram_we) begin
      vram_writes++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_vram_write: got addr 0x%0h data 0x%0h expected none", vram_addr, vram_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("vram_entry", {8'h00, vram_addr, vram_data}, {8'h00, mon_e.addr, mon_e.data});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    scan_busy = 1'b0; overflow_clr = 1'b0;
    repeat (3) tick();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_vram_we", 32'(vram_we), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    chk("rst_vram_addr", 32'(vram_addr), 32'd0);
    reset = 1'b0;
    tick();

    // Single write: VRAM strobe two cycles after acceptance.
    expect_wr(16'h0010, 8'h41);
    wr(16'h0010, 8'h41);
    chk("lat_n1_we", 32'(vram_we), 32'd0);
    chk("lat_n1_level", 32'(level), 32'd1);
    tick();
    chk("lat_n2_we", 32'(vram_we), 32'd1);
    tick();
    chk("lat_after_we", 32'(vram_we), 32'd0);
    chk("lat_after_level", 32'(level), 32'd0);

    // Fill while blocked, drop the ninth, drain one per cycle.
    scan_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expect_wr(16'(i), 8'h20 + 8'(i));
      wr(16'(i), 8'h20 + 8'(i));
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_level", 32'(level), 32'd8);
    wr(16'h0100, 8'h99);
    chk("drop1_overflow", 32'(overflow), 32'd1);
    chk("drop1_count", 32'(drop_count), 32'd1);
    chk("drop1_level", 32'(level), 32'd8);
    scan_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("drain_we", 32'(vram_we), 32'd1);
    end
    tick();
    chk("drain_done_we", 32'(vram_we), 32'd0);
    chk("drain_done_level", 32'(level), 32'd0);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("clr_overflow", 32'(overflow), 32'd0);
    chk("clr_count", 32'(drop_count), 32'd0);

    // Coalesce two writes to the same address while blocked.
    scan_busy = 1'b1;
    w0 = vram_writes;
    wr(16'h0005, 8'h41);
    wr(16'h0005, 8'h42);
    chk("coal_level", 32'(level), 32'd1);
    chk("coal_overflow", 32'(overflow), 32'd0);
    expect_wr(16'h0005, 8'h42);
    scan_busy = 1'b0;
    repeat (3) tick();
    chk("coal_writes", 32'(vram_writes - w0), 32'd1);

    // Full FIFO, pop and push in the same cycle.
    scan_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expect_wr(16'h0200 + 16'(i), 8'h50 + 8'(i));
      wr(16'h0200 + 16'(i), 8'h50 + 8'(i));
    end
    expect_wr(16'h0300, 8'h77);
    scan_busy = 1'b0;
    wr(16'h0300, 8'h77);
    chk("fullpp_level", 32'(level), 32'd8);
    chk("fullpp_full", 32'(full), 32'd1);
    chk("fullpp_overflow", 32'(overflow), 32'd0);
    chk("fullpp_count", 32'(drop_count), 32'd0);
    wait_empty("fullpp_drain_timeout");

    // Saturating drop counter, then clear colliding with a drop.
    scan_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expect_wr(16'h0400 + 16'(i), 8'h60 + 8'(i));
      wr(16'h0400 + 16'(i), 8'h60 + 8'(i));
    end
    wr_en = 1'b1; wr_addr = 16'h0500; wr_data = 8'hEE;
    repeat (300) tick();
    chk("sat_count", 32'(drop_count), 32'd255);
    chk("sat_overflow", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    tick();
    wr_en = 1'b0; overflow_clr = 1'b0;
    chk("clrdrop_overflow", 32'(overflow), 32'd1);
    chk("clrdrop_count", 32'(drop_count), 32'd1);
    scan_busy = 1'b0;
    wait_empty("sat_drain_timeout");
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;

    // Reset in the middle of a drain at level 4.
    scan_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr(16'h0600 + 16'(i), 8'h70 + 8'(i));
    end
    expect_wr(16'h0600, 8'h70);
    expect_wr(16'h0601, 8'h71);
    scan_busy = 1'b0;
    tick();
    tick();
    chk("mid_level", 32'(level), 32'd4);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_we", 32'(vram_we), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_full", 32'(full), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (10) tick();
    chk("post_rst_level", 32'(level), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_vram_write_buffer.md
TEXT_VRAM_WRITE_BUFFER -- requirements
Module: text_vram_write_buffer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter DEPTH, default 8, SHALL set the FIFO entry count (power of two, at least 2).
REQ-003 Parameter ADDR_W, default 16, SHALL set the text VRAM byte-address width.
REQ-004 Parameter DATA_W, default 8, SHALL set the character byte width.
REQ-005 Ports SHALL be exactly:
- clk  in  1  clock.
- reset  in  1  async active-high reset.
- wr_en  in  1  byte write from the memory adapter's text port.
- wr_addr  in  ADDR_W  VRAM-relative byte address.
- wr_data  in  DATA_W  character byte.
- scan_busy  in  1  scanout owns the VRAM port this cycle.
- overflow_clr  in  1  clears overflow.
- full  out  1  FIFO full.
- level  out  clog2(DEPTH)+1  occupied entries.
- vram_we  out  1  VRAM write strobe (registered).
- vram_addr  out  ADDR_W  VRAM write address (registered).
- vram_data  out  DATA_W  VRAM write data (registered).
- overflow  out  1  sticky: a write was dropped.
- drop_count  out  8  dropped writes, saturating.

Function
REQ-006 The FIFO SHALL store {addr,data} entries in order, with pointers wrapping modulo DEPTH.
REQ-007 Push: wr_en=1 and not coalesced SHALL append the entry at the clock edge if not full, or if full with a pop in the same cycle.
REQ-008 Coalesce: wr_en=1, level>0, wr_addr equals the newest entry's addr, and that entry is not being popped this cycle SHALL overwrite its data in place, leave level unchanged, and never count as a drop.
REQ-009 Pop: level>0 and scan_busy=0 SHALL pop the oldest entry and register vram_we=1 with its addr/data for the next cycle; otherwise vram_we=0 next cycle.
REQ-010 Minimum latency: a write accepted in cycle N with scan_busy=0 SHALL produce vram_we=1 in cycle N+2.
REQ-011 Throughput: with scan_busy=0 there SHALL be one pop per cycle, in FIFO order.
REQ-012 Drop: wr_en=1 that is neither pushed nor coalesced SHALL set overflow and increment drop_count, saturating at 255.
REQ-013 overflow_clr=1 SHALL clear overflow and drop_count; a drop in the same cycle SHALL win, giving overflow=1 and drop_count=1.
REQ-014 Outputs full and level SHALL be registered and reflect post-edge occupancy.
REQ-015 Control state machine:
- IDLE (level=0).
- DRAIN (level>0, scan_busy=0).
- BLOCKED (level>0, scan_busy=1).
- Transitions are evaluated every cycle from the next level and scan_busy.
- State is visible only through vram_we timing.
REQ-016 Simultaneous push and pop at level=0 SHALL NOT bypass the FIFO; the entry is popped no earlier than the next cycle.

Reset
REQ-017 Reset SHALL immediately clear:
- pointers, level=0, full=0;
- vram_we=0, vram_addr=0, vram_data=0;
- overflow=0, drop_count=0;
- state=IDLE.
REQ-018 Reset mid-drain SHALL discard all pending entries; no vram_we is issued after reset asserts.
REQ-019 FIFO storage contents need not be reset.

Structure
REQ-020 The {addr,data} entry typedef and the default parameter constants SHALL live in the shared defines package, alongside the text memory base and size.
REQ-021 Storage and pointers SHALL be a sub-module named sync_fifo_ram; coalescing, drop accounting and the state machine SHALL stay in the top module.

Verification
REQ-022 Single write 0x0010/0x41 with scan_busy=0 -> vram_we in cycle N+2 with addr 0x0010, data 0x41, then level=0.
REQ-023 scan_busy=1; writes 0x0000..0x0007 -> full=1; a 9th write to 0x0100 -> overflow=1, drop_count=1; release scan_busy -> 8 in-order VRAM writes, one per cycle.
REQ-024 scan_busy=1; writes 0x0005/0x41 then 0x0005/0x42 -> level=1; release -> single VRAM write with data 0x42.
REQ-025 Full FIFO with scan_busy=0 plus a write in the same cycle -> push accepted, no drop, level stays 8.
REQ-026 300 drops -> drop_count=255; overflow_clr together with a drop -> overflow=1, drop_count=1.
REQ-027 Reset asserted at level=4 mid-drain -> vram_we=0 and level=0 in the same cycle; no further VRAM writes.
